// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] ROW_INIT = 4'b0001;

  // Indexed [row][col]; row 3 carries the E,0,F,D bottom row of the pad.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_controller_stable_counter.sv
// Counts consecutive cycles of a held condition; done marks the final stable cycle.
module stable_counter #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic cond_i,
  output logic done_o
);

  localparam int W = (DEBOUNCE_CYCLES > 20'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [W-1:0] TERM = W'(DEBOUNCE_CYCLES - 20'd1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i || !cond_i) begin
      cnt_q <= '0;
    end else if (cnt_q != TERM) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = cond_i && (cnt_q == TERM);

endmodule

// File: rtl/keypad_scan_controller.sv
// Row scanner with press/release debounce; emits a key_valid pulse per accepted key.
// state    | meaning
// SCAN     | rotate one-hot row, sample columns at end of each dwell
// DEBOUNCE | row frozen, waiting for the single column to stay stable
// HELD     | key accepted, waiting for the latched column to drop
// RELEASE  | latched column low, waiting for it to stay low
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV        = 16'd4096,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sync_col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [15:0] DWELL_TERM = SCAN_DIV - 16'd1;

  state_t      state_q;
  logic [3:0]  row_q;
  logic [15:0] dwell_q;
  logic [3:0]  col_q;
  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic        key_held_q;

  logic [3:0]  row_d;
  logic        col_match;
  logic        col_low;
  logic        cnt_cond;
  logic        cnt_clr;
  logic        cnt_done;

  assign row_d     = {row_q[2:0], row_q[3]};
  assign col_match = (sync_col == col_q);
  assign col_low   = ((sync_col & col_q) == 4'h0);

  // One counter serves both debounce phases; it is held clear outside them.
  assign cnt_cond = ((state_q == DEBOUNCE) && col_match) ||
                    ((state_q == RELEASE) && col_low);
  assign cnt_clr  = (state_q == SCAN) || (state_q == HELD);

  stable_counter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_stable (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (cnt_clr),
    .cond_i (cnt_cond),
    .done_o (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= ROW_INIT;
      dwell_q     <= '0;
      col_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (dwell_q == DWELL_TERM) begin
            if ($onehot(sync_col)) begin
              col_q   <= sync_col;
              state_q <= DEBOUNCE;
            end else begin
              row_q   <= row_d;
              dwell_q <= '0;
            end
          end else begin
            dwell_q <= dwell_q + 16'd1;
          end
        end
        DEBOUNCE: begin
          if (!col_match) begin
            row_q   <= row_d;
            dwell_q <= '0;
            state_q <= SCAN;
          end else if (cnt_done) begin
            key_code_q  <= KEY_MAP[onehot_to_idx(row_q)][onehot_to_idx(col_q)];
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state_q     <= HELD;
          end
        end
        HELD: begin
          if (col_low) state_q <= RELEASE;
        end
        RELEASE: begin
          if (!col_low) begin
            state_q <= HELD;
          end else if (cnt_done) begin
            key_held_q <= 1'b0;
            row_q      <= row_d;
            dwell_q    <= '0;
            state_q    <= SCAN;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
